vip_raw_pattern_gen: RTL
========================

# vip_raw_pattern_gen

Synthesizable, parametrised CMOS-sensor timing and RAW Bayer pattern generator. It replaces the fixed 8-bit, 640x480, single-pattern behavioural stimulus with a source that configures data width, resolution, blanking, Bayer phase and test pattern. It drives the `per_frame_*` / `per_img_RAW` inputs of the RAW-to-RGB pipeline, both in simulation and on board when no sensor is fitted.

## Interface
- `DATA_W`, 8: RAW pixel width (8..16).
- `IMG_HDISP`, 640: active pixels per line (even, multiple of 8).
- `IMG_VDISP`, 480: active lines per frame (even).
- `H_SYNC`, 2: hsync pulse width in clocks (>=1).
- `H_BACK`, 2: clocks from the end of hsync to the first active pixel.
- `H_FRONT`, 2: clocks from the last active pixel to the next hsync.
- `V_SYNC`, 1: vsync width in lines (>=1).
- `V_BACK`, 1: lines from the end of vsync to the first active line.
- `V_FRONT`, 1: lines from the last active line to the next vsync.

Ports (name, direction, width, meaning):
- `clk` in 1: pixel clock; one clock; everything is on the rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `enable` in 1: run request.
- `mirror` in 2: Bayer phase select.
- `pattern_mode` in 2: test pattern select.
- `per_frame_vsync` out 1: vsync, active-low.
- `per_frame_hsync` out 1: hsync, active-low.
- `per_frame_href` out 1: active-pixel strobe, active-high.
- `per_img_RAW` out DATA_W: RAW pixel data.
- `frame_cnt` out 16: count of completed frames, wraps.
- `frame_done` out 1: one-cycle pulse on the last clock of each frame.

## Operation
- Geometry: H_TOTAL = H_SYNC+H_BACK+IMG_HDISP+H_FRONT; V_TOTAL = V_SYNC+V_BACK+IMG_VDISP+V_FRONT.
- Counters: h_cnt runs 0..H_TOTAL-1. v_cnt increments when h_cnt wraps and itself runs 0..V_TOTAL-1.
- FSM states:
  - IDLE: counters held at 0.
  - RUN: counters advance every clock.
- FSM transitions:
  - IDLE -> RUN on the first edge that samples `enable`=1.
  - In RUN, `enable`=0 sets stop_pending. The current frame always completes; at h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1 with stop_pending set, go to IDLE.
  - `enable` re-asserted before the frame end clears stop_pending, so there is no gap.
- Sync decode:
  - vsync low while v_cnt < V_SYNC.
  - hsync low while h_cnt < H_SYNC, on every line including vertical blanking.
  - href high when x = h_cnt-(H_SYNC+H_BACK) is in [0, IMG_HDISP) and y = v_cnt-(V_SYNC+V_BACK) is in [0, IMG_VDISP).
- `mirror` and `pattern_mode` are latched at h_cnt=0, v_cnt=0. Changes mid-frame take effect next frame.
- Bayer colour: row parity r = y[0]^mirror[1], column parity c = x[0]^mirror[0].
  - (r,c)=00 B, 01 G, 10 G, 11 R.
- Patterns (pixel value per mode):
  - 0 BAYER_CONST: B=100, G=150, R=200, each left-shifted by DATA_W-8.
  - 1 H_RAMP: (x + frame_cnt) mod 2^DATA_W.
  - 2 V_RAMP: y mod 2^DATA_W.
  - 3 COLOR_BARS: bar index b = x / (IMG_HDISP/8). Pixel = max (all ones) if that pixel's colour bit is set in b (bit2=R, bit1=G, bit0=B), else 0.
- Blanking: `per_img_RAW` = 0 whenever href is low.
- Arithmetic: x and y are unsigned, sized $clog2 of H_TOTAL and V_TOTAL. All truncation is modulo 2^DATA_W.
- Reset: async `rst` forces IDLE, clears stop_pending and counters, and sets outputs to:
  - vsync=1, hsync=1, href=0, RAW=0, frame_cnt=0, frame_done=0.
  - A reset mid-frame aborts the frame with no frame_done.

## Timing
- All outputs are registered and lag the counter position by 1 clock.
- `enable` first sampled high at edge N: state=RUN at N. At N+1 the outputs show position (0,0): vsync=0, hsync=0.
- First href high: H_SYNC+H_BACK+(V_SYNC+V_BACK)*H_TOTAL clocks after N+1.
- frame_done: high for exactly the 1 clock whose outputs show (H_TOTAL-1, V_TOTAL-1). frame_cnt increments on that same edge; 0xFFFF wraps to 0.
- Back-to-back frames: the next vsync falls on the clock right after frame_done, with no idle clock.
- Stop: after the final frame_done, outputs return to reset levels on the next clock and stay there.

## Structure
- Package `vip_pattern_pkg` holds:
  - pattern_mode enum (BAYER_CONST, H_RAMP, V_RAMP, COLOR_BARS);
  - Bayer colour enum (B, GB, GR, R);
  - the constants 100/150/200.
- Sub-module `vip_timing_counter`: h/v counters, FSM, stop_pending, sync/href decode. It outputs x, y, active and frame_last.
- Top level: parameter latching, pixel generation and output registers.

## Test plan
Bench parameters: IMG 8x4, H 2/2/2, V 1/1/1 → H_TOTAL=14, V_TOTAL=7, 98 clocks per frame.
- Reset then `enable`=1 with mode 0, mirror 00 → line y=0 RAW 100,150,100,150…; line y=1 150,200…; 32 href clocks per frame; frame_done every 98 clocks.
- mirror=11, mode 0 → line y=0 starts 200,150; `DATA_W`=10 → values 400/600/800.
- Mode 1 → frame 0, line 0 RAW 0..7; frame 1 RAW 1..8. Mode 3 → 8 bars; bar 5 has R and B=max, G=0.
- `enable` dropped mid-frame 0 → frame completes, frame_done pulses once, frame_cnt=1, then vsync/hsync=1, href=0 indefinitely.
- Assert `rst` mid-line → all outputs at reset values asynchronously; restart gives vsync low at N+1. Change mode mid-frame → applies only from the next frame.

Source files
------------

// File: rtl/vip_pattern_pkg.sv
// vip_pattern_pkg: shared pattern/colour enums and Bayer constant levels
package vip_pattern_pkg;
  typedef enum logic [1:0] {BAYER_CONST, H_RAMP, V_RAMP, COLOR_BARS} pattern_e;
  typedef enum logic [1:0] {B, GB, GR, R} bayer_e;
  localparam int VAL_B = 100;
  localparam int VAL_G = 150;
  localparam int VAL_R = 200;
endpackage

// File: rtl/vip_timing_counter.sv
// vip_timing_counter: run/idle FSM, h/v raster counters and sync/active decode
module vip_timing_counter #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int H_SYNC    = 2,
  parameter int H_BACK    = 2,
  parameter int H_FRONT   = 2,
  parameter int V_SYNC    = 1,
  parameter int V_BACK    = 1,
  parameter int V_FRONT   = 1,
  localparam int H_TOTAL  = H_SYNC + H_BACK + IMG_HDISP + H_FRONT,
  localparam int V_TOTAL  = V_SYNC + V_BACK + IMG_VDISP + V_FRONT,
  localparam int XW       = $clog2(H_TOTAL),
  localparam int YW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          active_o,
  output logic          frame_first_o,
  output logic          frame_last_o,
  output logic          vsync_o,
  output logic          hsync_o
);
  typedef enum logic {IDLE, RUN} state_e;
  state_e state_q, state_d;
  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;
  logic stop_q, stop_d;
  logic run, h_last, v_last;
  assign run    = state_q == RUN;
  assign h_last = h_q == XW'(H_TOTAL - 1);
  assign v_last = v_q == YW'(V_TOTAL - 1);
  // x/y wrap to large values in blanking, so a single upper-bound compare finds the active window
  assign x_o           = h_q - XW'(H_SYNC + H_BACK);
  assign y_o           = v_q - YW'(V_SYNC + V_BACK);
  assign active_o      = run && x_o < XW'(IMG_HDISP) && y_o < YW'(IMG_VDISP);
  assign frame_first_o = run && h_q == '0 && v_q == '0;
  assign frame_last_o  = run && h_last && v_last;
  assign vsync_o       = !(run && v_q < YW'(V_SYNC));
  assign hsync_o       = !(run && h_q < XW'(H_SYNC));
  // next state: idle holds counters at origin; run always finishes the frame before honouring a stop
  always_comb begin
    state_d = state_q;
    stop_d  = 1'b0;
    h_d     = '0;
    v_d     = '0;
    if (!run) begin
      state_d = enable_i ? RUN : IDLE;
    end else begin
      stop_d  = !enable_i;
      h_d     = h_last ? '0 : h_q + 1'b1;
      v_d     = h_last ? (v_last ? '0 : v_q + 1'b1) : v_q;
      state_d = (frame_last_o && stop_q) ? IDLE : RUN;
    end
  end
  // state and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stop_q  <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end
endmodule

// File: rtl/vip_raw_pattern_gen.sv
// vip_raw_pattern_gen: parametrised sensor timing and RAW Bayer test pattern source
module vip_raw_pattern_gen
  import vip_pattern_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int H_SYNC    = 2,
  parameter int H_BACK    = 2,
  parameter int H_FRONT   = 2,
  parameter int V_SYNC    = 1,
  parameter int V_BACK    = 1,
  parameter int V_FRONT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mirror,
  input  logic [1:0]        pattern_mode,
  output logic              per_frame_vsync,
  output logic              per_frame_hsync,
  output logic              per_frame_href,
  output logic [DATA_W-1:0] per_img_RAW,
  output logic [15:0]       frame_cnt,
  output logic              frame_done
);
  localparam int XW = $clog2(H_SYNC + H_BACK + IMG_HDISP + H_FRONT);
  localparam int YW = $clog2(V_SYNC + V_BACK + IMG_VDISP + V_FRONT);
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic active, frame_first, frame_last, vsync, hsync;
  logic [1:0] mirror_q;
  pattern_e mode_q;
  logic vsync_q, hsync_q, href_q, done_q;
  logic [DATA_W-1:0] raw_q, const_v, pix;
  logic [15:0] fcnt_q;
  bayer_e col;
  logic [2:0] bar;
  logic bar_on;
  vip_timing_counter #(
    .IMG_HDISP(IMG_HDISP), .IMG_VDISP(IMG_VDISP),
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
  ) u_timing (
    .clk(clk), .rst(rst), .enable_i(enable),
    .x_o(x), .y_o(y), .active_o(active),
    .frame_first_o(frame_first), .frame_last_o(frame_last),
    .vsync_o(vsync), .hsync_o(hsync)
  );
  assign col     = bayer_e'({y[0] ^ mirror_q[1], x[0] ^ mirror_q[0]});
  assign bar     = 3'(x / XW'(IMG_HDISP / 8));
  assign bar_on  = col == R ? bar[2] : col == B ? bar[0] : bar[1];
  assign const_v = col == B ? DATA_W'(VAL_B << (DATA_W - 8)) :
                   col == R ? DATA_W'(VAL_R << (DATA_W - 8)) : DATA_W'(VAL_G << (DATA_W - 8));
  assign pix     = mode_q == BAYER_CONST ? const_v :
                   mode_q == H_RAMP      ? DATA_W'(32'(x) + 32'(fcnt_q)) :
                   mode_q == V_RAMP      ? DATA_W'(32'(y)) : {DATA_W{bar_on}};
  assign per_frame_vsync = vsync_q;
  assign per_frame_hsync = hsync_q;
  assign per_frame_href  = href_q;
  assign per_img_RAW     = raw_q;
  assign frame_cnt       = fcnt_q;
  assign frame_done      = done_q;
  // frame-origin latch of pattern controls and registered video outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mirror_q <= '0;
      mode_q   <= BAYER_CONST;
      vsync_q  <= 1'b1;
      hsync_q  <= 1'b1;
      href_q   <= 1'b0;
      raw_q    <= '0;
      done_q   <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      mirror_q <= frame_first ? mirror : mirror_q;
      mode_q   <= frame_first ? pattern_e'(pattern_mode) : mode_q;
      vsync_q  <= vsync;
      hsync_q  <= hsync;
      href_q   <= active;
      raw_q    <= active ? pix : '0;
      done_q   <= frame_last;
      fcnt_q   <= fcnt_q + 16'(frame_last);
    end
  end
endmodule
